// File: rtl/sync_debounce_pkg.sv
// -----------------------------------------------------------------------------
// sync_debounce_pkg
// Shared helpers for the sync_debounce input conditioner.
//   clog2_f     : ceiling log2 of a positive integer (constant-evaluable)
//   ctr_width_f : stability-counter width, never narrower than one bit
// -----------------------------------------------------------------------------
package sync_debounce_pkg;

    function automatic int clog2_f(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // A single-cycle debounce still needs a one-bit counter to keep the
    // declaration legal, even though the counter never leaves zero.
    function automatic int ctr_width_f(input int cycles);
        int w;
        w = clog2_f(cycles);
        return (w > 1) ? w : 1;
    endfunction

endpackage : sync_debounce_pkg

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One bit of the input conditioner: SYNC_STAGES-deep synchroniser followed by
// a stability counter that only moves the output after DEBOUNCE_CYCLES
// consecutive disagreeing samples. Bypass makes the output track the
// synchronised input directly.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   async_i      : raw asynchronous input bit
//   bypass_i     : 1 = output follows synchronised input every edge
//   out_o        : registered debounced level
//   rise_o/fall_o: registered one-cycle edge pulses, coincident with out_o
//   event_next_o : pulse that will be registered on the next edge, used by
//                  the top to register the aggregate change flag in step
// -----------------------------------------------------------------------------
module debounce_channel
    import sync_debounce_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 1000,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    input  logic bypass_i,
    output logic out_o,
    output logic rise_o,
    output logic fall_o,
    output logic event_next_o
);

    localparam int              W_CTR    = ctr_width_f(DEBOUNCE_CYCLES);
    localparam logic [W_CTR-1:0] CTR_LAST = W_CTR'(DEBOUNCE_CYCLES - 1);
    localparam logic [W_CTR-1:0] CTR_ZERO = {W_CTR{1'b0}};
    localparam logic [W_CTR-1:0] CTR_ONE  = W_CTR'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic [W_CTR-1:0]       cnt_q, cnt_d;
    logic                   out_q, out_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Synchroniser: plain shift register, nothing between stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_BIT}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
        end
    end

    // Next-state for level, stability counter and edge pulses.
    always_comb begin
        out_d = out_q;
        cnt_d = CTR_ZERO;
        if (bypass_i) begin
            // Any partial count is dropped; output tracks the sync chain.
            out_d = sync_s;
            cnt_d = CTR_ZERO;
        end else if (sync_s == out_q) begin
            // Input agrees again: a glitch shorter than the window is rejected.
            cnt_d = CTR_ZERO;
        end else if (cnt_q == CTR_LAST) begin
            out_d = sync_s;
            cnt_d = CTR_ZERO;
        end else begin
            cnt_d = cnt_q + CTR_ONE;
        end
        rise_d = out_d & ~out_q;
        fall_d = ~out_d & out_q;
    end

    // Level, counter and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= RESET_BIT;
            cnt_q  <= CTR_ZERO;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign out_o        = out_q;
    assign rise_o       = rise_q;
    assign fall_o       = fall_q;
    assign event_next_o = rise_d | fall_d;

endmodule : debounce_channel

// File: rtl/sync_debounce.sv
// -----------------------------------------------------------------------------
// sync_debounce
// Multi-channel synchroniser + debouncer for bouncy asynchronous level inputs.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   async_in   : N_CHANNELS raw asynchronous inputs
//   bypass     : 1 = plain multi-stage synchroniser (no debounce)
//   out        : registered debounced levels
//   rise, fall : registered one-cycle pulses when out[i] goes 0->1 / 1->0
//   changed    : registered OR of all pulses, same cycle as the pulses
// -----------------------------------------------------------------------------
module sync_debounce
    import sync_debounce_pkg::*;
#(
    parameter int                    N_CHANNELS      = 8,
    parameter int                    SYNC_STAGES     = 2,
    parameter int                    DEBOUNCE_CYCLES = 1000,
    parameter logic [N_CHANNELS-1:0] RESET_VALUE     = {N_CHANNELS{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CHANNELS-1:0] async_in,
    input  logic                  bypass,
    output logic [N_CHANNELS-1:0] out,
    output logic [N_CHANNELS-1:0] rise,
    output logic [N_CHANNELS-1:0] fall,
    output logic                  changed
);

    logic [N_CHANNELS-1:0] event_next_s;
    logic                  changed_q;

    for (genvar g = 0; g < N_CHANNELS; g++) begin : g_chan
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_BIT       (RESET_VALUE[g])
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .async_i      (async_in[g]),
            .bypass_i     (bypass),
            .out_o        (out[g]),
            .rise_o       (rise[g]),
            .fall_o       (fall[g]),
            .event_next_o (event_next_s[g])
        );
    end

    // Aggregate change flag, registered from the channels' next pulses so it
    // lines up with rise/fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= |event_next_s;
        end
    end

    assign changed = changed_q;

endmodule : sync_debounce

// File: tb/tb_sync_debounce.sv
module tb_sync_debounce;

    localparam int         N   = 4;
    localparam int         SYN = 2;
    localparam int         DEB = 4;
    localparam logic [3:0] RV  = 4'b0101;

    logic       clk;
    logic       rst_n;
    logic [3:0] async_in;
    logic       bypass;
    logic [3:0] out, rise, fall;
    logic       changed;

    sync_debounce #(
        .N_CHANNELS      (N),
        .SYNC_STAGES     (SYN),
        .DEBOUNCE_CYCLES (DEB),
        .RESET_VALUE     (RV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (async_in),
        .bypass   (bypass),
        .out      (out),
        .rise     (rise),
        .fall     (fall),
        .changed  (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] out;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       changed;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    // Reference model: history of input samples since the last reset, the
    // current expected level and the edge of each channel's last output event
    // (reset release, level change, or bypass edge).
    logic [3:0] hist[$];
    int         edge_n;
    logic [3:0] out_m;
    int         last_evt[N];

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s t=%0t: got %b expected %b", name, $time, got, expv);
    endtask

    // Value the last synchroniser stage shows just before edge j.
    function automatic logic s_before(input int ch, input int j);
        int k;
        k = j - SYN;
        if (k < 1) return RV[ch];
        return hist[k-1][ch];
    endfunction

    task automatic model_step(input logic [3:0] a, input logic b, input logic r);
        exp_t       e;
        logic [3:0] nxt;
        logic       all_diff;
        if (!r) begin
            edge_n = 0;
            hist.delete();
            out_m = RV;
            for (int c = 0; c < N; c++) last_evt[c] = 0;
            e.out = RV; e.rise = 4'b0000; e.fall = 4'b0000; e.changed = 1'b0;
            exp_q.push_back(e);
        end else begin
            edge_n++;
            hist.push_back(a);
            nxt = out_m;
            for (int c = 0; c < N; c++) begin
                if (b) begin
                    nxt[c] = s_before(c, edge_n);
                    last_evt[c] = edge_n;
                end else if (edge_n - last_evt[c] >= DEB) begin
                    // Change only if the last DEB debounce-mode samples all disagree.
                    all_diff = 1'b1;
                    for (int j = edge_n - DEB + 1; j <= edge_n; j++)
                        if (s_before(c, j) == out_m[c]) all_diff = 1'b0;
                    if (all_diff) begin
                        nxt[c] = ~out_m[c];
                        last_evt[c] = edge_n;
                    end
                end
            end
            e.out = nxt;
            e.rise = nxt & ~out_m;
            e.fall = ~nxt & out_m;
            e.changed = |(e.rise | e.fall);
            exp_q.push_back(e);
            out_m = nxt;
        end
    endtask

    task automatic tick(input logic [3:0] a, input logic b, input logic r);
        @(negedge clk);
        async_in = a;
        bypass   = b;
        if (!r && rst_n) begin
            rst_n = 1'b0;
            #1;
            chk("async_rst_out", out, RV);
            chk("async_rst_pulses", rise | fall, 4'b0000);
            chk("async_rst_changed", {3'b000, changed}, 4'b0000);
        end
        rst_n = r;
        model_step(a, b, r);
    endtask

    task automatic repeat_tick(input int n, input logic [3:0] a, input logic b);
        for (int i = 0; i < n; i++) tick(a, b, 1'b1);
    endtask

    // Monitor: every edge the DUT presents a new output set; compare it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out", out, e.out);
                chk("rise", rise, e.rise);
                chk("fall", fall, e.fall);
                chk("changed", {3'b000, changed}, {3'b000, e.changed});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] lvl, a;
        logic       b;
        int         bounce;
        rst_n    = 1'b0;
        async_in = RV;
        bypass   = 1'b0;
        edge_n   = 0;
        out_m    = RV;
        for (int c = 0; c < N; c++) last_evt[c] = 0;

        // Reset held, then released with inputs equal to the reset value.
        for (int i = 0; i < 3; i++) tick(RV, 1'b0, 1'b0);
        repeat_tick(20, 4'b0101, 1'b0);
        // Clean step on ch0: settle low, then step high.
        repeat_tick(10, 4'b0100, 1'b0);
        repeat_tick(10, 4'b0101, 1'b0);
        // Glitch on ch1: 3 cycles rejected, 4 cycles accepted.
        repeat_tick(3, 4'b0111, 1'b0);
        repeat_tick(10, 4'b0101, 1'b0);
        repeat_tick(4, 4'b0111, 1'b0);
        repeat_tick(12, 4'b0101, 1'b0);
        // Simultaneous opposite events on ch2/ch3.
        repeat_tick(10, 4'b1001, 1'b0);
        repeat_tick(10, 4'b0101, 1'b0);
        // Bypass following, then bypass asserted with a partial count.
        repeat_tick(5, 4'b0100, 1'b1);
        repeat_tick(5, 4'b0101, 1'b1);
        repeat_tick(3, 4'b0101, 1'b0);
        repeat_tick(4, 4'b0100, 1'b0);
        repeat_tick(3, 4'b0100, 1'b1);
        repeat_tick(8, 4'b0101, 1'b0);
        // Toggle every cycle never gets through.
        for (int i = 0; i < 12; i++) tick((i % 2 == 0) ? 4'b1010 : 4'b0101, 1'b0, 1'b1);
        repeat_tick(8, 4'b0101, 1'b0);
        // Reset mid-count with the input still changed.
        repeat_tick(4, 4'b0100, 1'b0);
        tick(4'b0100, 1'b0, 1'b0);
        repeat_tick(10, 4'b0100, 1'b0);

        // Randomised phase: level changes, bounce bursts, bypass and resets.
        lvl = 4'b0100;
        b = 1'b0;
        bounce = 0;
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 9) == 0) lvl[c] = ~lvl[c];
            if (bounce == 0 && $urandom_range(0, 24) == 0) bounce = $urandom_range(1, 6);
            a = lvl;
            if (bounce > 0) begin
                a = lvl ^ 4'($urandom_range(0, 15));
                bounce--;
            end
            if ($urandom_range(0, 39) == 0) b = ~b;
            if ($urandom_range(0, 199) == 0) tick(a, b, 1'b0);
            else tick(a, b, 1'b1);
        end
        repeat_tick(12, lvl, 1'b0);

        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_sync_debounce
